thrash_sync_fifo: RTL
=====================

// Module: thrash_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO for passing data between generated threads (producer A ->
//  consumer B) that run under the run_req/busy handshake. Successor to the fixed 32-bit FIFO:
//  generic width/depth, ce stall, occupancy count, programmable almost-flags, sticky error
//  flags, synchronous flush, and selectable standard/FWFT read mode.
// PARAMETERS
//  WIDTH       32  data word width in bits (>=1)
//  DEPTH_LOG2  4   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (>=1)
//  AF_LEVEL    12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clock         in   1             single clock, rising edge
//  reset_n       in   1             asynchronous reset, active-low
//  ce            in   1             clock enable; 0 freezes all state
//  clear         in   1             synchronous flush
//  we            in   1             write request
//  wdata         in   WIDTH         write data
//  re            in   1             read request
//  rdata         out  WIDTH         read data
//  rvalid        out  1             rdata valid
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  count         out  DEPTH_LOG2+1  occupancy, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (reset_n=0, async): wr_ptr, rd_ptr, count = 0; rdata = 0; rvalid = 0;
//    overflow = underflow = 0. Hence empty=1, full=0, almost_empty=1, almost_full=0.
//    Reset mid-transfer discards all contents immediately.
//  - Storage memory is not reset.
//  - ce=0: no pointer, count, flag, rdata or rvalid update; we/re/clear are ignored.
//  - Priority when ce=1: clear > (write, read).
//  - clear: pointers, count, rvalid, overflow and underflow go to 0 on the next edge.
//    rdata holds its value. Concurrent we/re are dropped and flag no errors.
//  - Write accept: we && !full. Word goes to mem[wr_ptr]; wr_ptr increments mod DEPTH.
//  - Read accept: re && !empty. rd_ptr increments mod DEPTH.
//  - Acceptance uses the pre-edge state only. At full, simultaneous we+re: read accepted,
//    write rejected (overflow set); count becomes DEPTH-1. At empty, simultaneous we+re:
//    write accepted, read rejected (underflow set); count becomes 1.
//  - count: +1 write only; -1 read only; unchanged for both or neither. Never leaves 0..DEPTH.
//  - Status flags are combinational decodes of the registered count. A written word is visible
//    (empty=0) on the cycle after the write edge.
//  - overflow / underflow: set on a rejected we / re. Cleared only by reset or clear.
//  - Standard read mode (macro absent): on an accepted read, rdata <= mem[rd_ptr] and
//    rvalid <= 1 at that edge (1-cycle latency). rvalid = 0 after any edge with no accepted
//    read. rdata holds its last value otherwise.
//  - Back-to-back reads give one word per cycle.
//  - Pointer wrap: DEPTH is a power of 2; pointers are DEPTH_LOG2 bits and wrap naturally.
//    full/empty are taken from count, not from pointer comparison.
// CONFIGURATION
//  THRASH_FIFO_FWFT_EN defined: first-word-fall-through mode.
//    - rdata = mem[rd_ptr] continuously (combinational head) and rvalid = !empty.
//    - re with rvalid=1 consumes the head; the next word appears after that edge.
//    - Write-to-rvalid latency: 1 cycle.
//    - Reset/clear force rvalid=0; rdata is don't-care while rvalid=0.
//  THRASH_FIFO_FWFT_EN undefined: standard registered read as in BEHAVIOUR.
// TESTING (WIDTH=32, DEPTH_LOG2=4, AF_LEVEL=12, AE_LEVEL=2)
//  1 Reset, then write 0x1..0x10 on consecutive cycles:
//    count=16, full=1, almost_full=1 from 12th write.
//    Read 16: rdata 0x1..0x10 in order, rvalid 1 cycle after each re; empty=1 at end.
//  2 Fill to 16, then pulse we with wdata 0xDEAD:
//    overflow=1, count stays 16, 0xDEAD never read.
//    Then we+re same cycle at full: count=15, overflow stays 1.
//  3 Empty FIFO, pulse re: underflow=1, rvalid=0.
//    Then we(0xA5)+re together: count=1, 0xA5 is the next word read.
//  4 Write 10, hold ce=0 with we/re/clear toggling for 5 cycles: count stays 10, no flag change.
//    Then clear with ce=1: count=0, empty=1, overflow=underflow=0.
//  5 Stream 40 words with continuous we/re at count~8: pointer wrap twice, data in order,
//    no flags set. Assert reset_n=0 mid-stream: count=0 and rvalid=0 without waiting for clock.
//  6 THRASH_FIFO_FWFT_EN: write 0x55 -> next cycle rvalid=1, rdata=0x55 with no re.
//    re -> empty=1, rvalid=0.

Source files
------------

// File: rtl/thrash_sync_fifo.sv
// Parametrised single-clock FIFO with ce stall, occupancy count, almost-flags and sticky errors.
// Define THRASH_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module thrash_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  clear,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  advance;

  // Handshake: a write is taken on an edge where ce && !clear && we && !full, a read where
  // ce && !clear && re && !empty; both decisions use only the state before that edge.
  assign advance = ce && !clear;
  assign wr_acc  = advance && we && !full;
  assign rd_acc  = advance && re && !empty;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (ce) begin
      if (clear) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count_q     <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (we && full)  overflow_q  <= 1'b1;
        if (re && empty) underflow_q <= 1'b1;
      end
    end
  end

`ifdef THRASH_FIFO_FWFT_EN
  // Head word is presented combinationally; it is valid whenever the FIFO holds data.
  assign rdata  = mem[rd_ptr];
  assign rvalid = !empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (ce) begin
      if (clear) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rd_ptr];
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule
